systolic_seq_ctrl: RTL and testbench

Sequencer for a ROWS×COLS weight-stationary systolic array of 8-bit MAC PEs. Every PE in the array shares a single load_weight_en; weights shift down the column sum path while it is high. This block:
- loads one weight tile into the array;
- streams skewed activation vectors in across the rows;
- de-skews the column sums leaving the bottom row and presents them as aligned result vectors;
- pulses done once the last result has left.

---
 rtl/systolic_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a weight-stationary systolic array: weight load,
// skewed activation streaming, result de-skew and job completion.
module systolic_seq_ctrl #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int OUT_LAT = ROWS + 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vecs,
  output logic               busy,
  output logic               done,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [COLS*8-1:0]  w_data,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [ROWS*8-1:0]  a_data,
  output logic               load_weight_en,
  output logic [ROWS*8-1:0]  arr_a_in,
  output logic [COLS*32-1:0] arr_sum_in,
  input  logic [COLS*32-1:0] arr_sum_out,
  output logic               r_valid,
  output logic [COLS*32-1:0] r_data
);

  localparam int L  = 1 + OUT_LAT + COLS - 1;
  localparam int WW = $clog2(ROWS + 1);
  localparam int DW = $clog2(L + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, STREAM, DRAIN, DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]   nv;
  logic [CNT_W-1:0]   iss_cnt;
  logic [WW-1:0]      w_cnt;
  logic [DW-1:0]      drn_cnt;
  logic [L-1:0]       tag;
  logic [COLS*32-1:0] sx;
  logic [COLS*32-1:0] dsk;
  logic [ROWS*8-1:0]  a_inj;
  logic               w_fire, a_fire;
  logic               last_w, last_a, drn_end;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign w_ready = (state == LOAD);
  assign a_ready = (state == STREAM) && (iss_cnt < nv);
  assign w_fire  = w_valid & w_ready;
  assign a_fire  = a_valid & a_ready;
  assign last_w  = (w_cnt == WW'(ROWS - 1));
  assign last_a  = ((iss_cnt + CNT_W'(1)) == nv);
  assign drn_end = (drn_cnt == DW'(L - 1));
  assign a_inj   = a_fire ? a_data : '0;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    if (w_fire && last_w)
                 state_n = (nv == '0) ? DRAIN : STREAM;
      STREAM:  if (a_fire && last_a) state_n = DRAIN;
      DRAIN:   if (drn_end) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      nv             <= '0;
      iss_cnt        <= '0;
      w_cnt          <= '0;
      drn_cnt        <= '0;
      tag            <= '0;
      load_weight_en <= 1'b0;
      arr_sum_in     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) nv <= num_vecs;
      if (state != LOAD) w_cnt <= '0;
      else if (w_fire) w_cnt <= w_cnt + WW'(1);
      if (state == IDLE) iss_cnt <= '0;
      else if (a_fire) iss_cnt <= iss_cnt + CNT_W'(1);
      if (state != DRAIN) drn_cnt <= '0;
      else drn_cnt <= drn_cnt + DW'(1);
      tag            <= {tag[L-2:0], a_fire};
      load_weight_en <= w_fire;
      arr_sum_in     <= w_fire ? sx : '0;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_sx
    assign sx[32*c +: 32] = {{24{w_data[8*c+7]}}, w_data[8*c +: 8]};
  end

  // Row r sits r cycles behind row 0 to match the array's diagonal wavefront
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [7:0] sr [r+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= r; i++) sr[i] <= '0;
      end else begin
        sr[0] <= a_inj[8*r +: 8];
        for (int i = 1; i <= r; i++) sr[i] <= sr[i-1];
      end
    end
    assign arr_a_in[8*r +: 8] = sr[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign dsk[32*c +: 32] = arr_sum_out[32*c +: 32];
    end else begin : g_dly
      logic [31:0] sr [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= arr_sum_out[32*c +: 32];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign dsk[32*c +: 32] = sr[D-1];
    end
  end

  assign r_valid = tag[L-1];
  assign r_data  = r_valid ? dsk : '0;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural
// 4x4 weight-stationary array model closing the loop.
module tb_systolic_seq_ctrl;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int OUT_LAT = ROWS + 3;
  localparam int CNT_W   = 16;
  localparam int L       = 1 + OUT_LAT + COLS - 1;

  localparam logic [127:0] ID_W   = {32'h0000_0001, 32'h0000_0100,
                                     32'h0001_0000, 32'h0100_0000};
  localparam logic [127:0] ONES_W = {4{32'h0101_0101}};

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   num_vecs = '0;
  logic               busy, done;
  logic               w_valid = 1'b0;
  logic               w_ready;
  logic [COLS*8-1:0]  w_data = '0;
  logic               a_valid = 1'b0;
  logic               a_ready;
  logic [ROWS*8-1:0]  a_data = '0;
  logic               load_weight_en;
  logic [ROWS*8-1:0]  arr_a_in;
  logic [COLS*32-1:0] arr_sum_in;
  logic [COLS*32-1:0] arr_sum_out;
  logic               r_valid;
  logic [COLS*32-1:0] r_data;

  systolic_seq_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .OUT_LAT(OUT_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .load_weight_en(load_weight_en), .arr_a_in(arr_a_in),
    .arr_sum_in(arr_sum_in), .arr_sum_out(arr_sum_out),
    .r_valid(r_valid), .r_data(r_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Array model: weights shift down on load; column c in cycle T sums
  // row r's input from cycle T-OUT_LAT-c+r.
  int                w [ROWS][COLS];
  logic [ROWS*8-1:0] hist [16];
  int                acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) hist[i] <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) w[r][c] <= 0;
    end else begin
      hist[0] <= arr_a_in;
      for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
      if (load_weight_en)
        for (int c = 0; c < COLS; c++) begin
          w[0][c] <= $signed(arr_sum_in[32*c +: 32]);
          for (int r = 1; r < ROWS; r++) w[r][c] <= w[r-1][c];
        end
    end
  end

  always_comb begin
    arr_sum_out = '0;
    acc = 0;
    for (int c = 0; c < COLS; c++) begin
      acc = 0;
      for (int r = 0; r < ROWS; r++)
        acc += w[r][c] * int'($signed(hist[OUT_LAT+c-r-1][8*r +: 8]));
      arr_sum_out[32*c +: 32] = acc;
    end
  end

  logic [127:0] rq_d [$];
  int           rq_c [$];
  int lwe_cnt = 0, ar_cnt = 0, done_cnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (r_valid) begin
        rq_d.push_back(r_data);
        rq_c.push_back(cyc);
      end
      if (load_weight_en) lwe_cnt++;
      if (a_ready) ar_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    num_vecs = CNT_W'(n);
    step();
    start = 1'b0;
  endtask

  task automatic load_w(input logic [127:0] rows, input int gap);
    for (int i = 0; i < ROWS; i++) begin
      w_valid = 1'b1;
      w_data = rows[32*i +: 32];
      chk("w_ready_beat", w_ready, 1'b1);
      step();
      w_valid = 1'b0;
      w_data = '0;
      repeat (gap) step();
    end
  endtask

  task automatic send_vec(input logic [31:0] d, output int at);
    int k = 0;
    a_valid = 1'b1;
    a_data = d;
    while (!a_ready && k < 20) begin step(); k++; end
    chk("a_ready_vec", a_ready, 1'b1);
    at = cyc;
    step();
    a_valid = 1'b0;
    a_data = '0;
  endtask

  task automatic wait_done(input int base, input int lim);
    int k = 0;
    while (done_cnt == base && k < lim) begin step(); k++; end
    chk("done_seen", done_cnt != base, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  int bq, bd, bl, ba, t0, t1;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {busy, done, w_ready, a_ready, load_weight_en, r_valid}, 6'b0);
    chk("rst_a_in", arr_a_in, '0);
    chk("rst_sum_in", arr_sum_in, '0);
    chk("rst_r_data", r_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // identity load, one vector
    bq = rq_d.size(); bd = done_cnt; bl = lwe_cnt;
    start_job(1);
    chk("t1_busy", busy, 1'b1);
    load_w(ID_W, 0);
    send_vec(32'h0403_0201, t0);
    wait_done(bd, 40);
    chk("t1_done_cyc", done_cyc - t0, L + 1);
    repeat (3) step();
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_ndone", done_cnt - bd, 1);
    chk("t1_nres", rq_d.size() - bq, 1);
    chk("t1_lat", rq_c[bq] - t0, L);
    chk("t1_data", rq_d[bq], {32'd4, 32'd3, 32'd2, 32'd1});
    chk("t1_lwe", lwe_cnt - bl, 4);
    chk("t1_idle_rdata", r_data, '0);

    // all-ones weights, back-to-back vectors, ignored start/w_valid
    bq = rq_d.size(); bd = done_cnt; bl = lwe_cnt;
    start_job(2);
    load_w(ONES_W, 0);
    a_valid = 1'b1;
    a_data = 32'h0101_0101;
    chk("t2_a_ready", a_ready, 1'b1);
    t0 = cyc;
    step();
    a_data = 32'h0003_FF02;
    step();
    a_valid = 1'b0;
    chk("t2_a_ready_off", a_ready, 1'b0);
    start = 1'b1; num_vecs = 16'd7;
    w_valid = 1'b1; w_data = 32'hFFFF_FFFF;
    step();
    start = 1'b0; w_valid = 1'b0; w_data = '0;
    wait_done(bd, 40);
    repeat (3) step();
    chk("t2_nres", rq_d.size() - bq, 2);
    chk("t2_lat", rq_c[bq] - t0, L);
    chk("t2_gap", rq_c[bq+1] - rq_c[bq], 1);
    chk("t2_d0", rq_d[bq], {4{32'd4}});
    chk("t2_d1", rq_d[bq+1], {4{32'd4}});
    chk("t2_lwe", lwe_cnt - bl, 4);
    chk("t2_ndone", done_cnt - bd, 1);
    chk("t2_busy_low", busy, 1'b0);

    // bubbles: valid pattern 1,0,0,1
    bq = rq_d.size(); bd = done_cnt;
    start_job(2);
    load_w(ID_W, 0);
    send_vec(32'h0807_0605, t0);
    step();
    step();
    send_vec(32'hFCFD_FEFF, t1);
    chk("t3_issue_gap", t1 - t0, 3);
    wait_done(bd, 40);
    repeat (3) step();
    chk("t3_nres", rq_d.size() - bq, 2);
    chk("t3_gap", rq_c[bq+1] - rq_c[bq], 3);
    chk("t3_d0", rq_d[bq], {32'd8, 32'd7, 32'd6, 32'd5});
    chk("t3_d1", rq_d[bq+1], {32'hFFFF_FFFC, 32'hFFFF_FFFD,
                              32'hFFFF_FFFE, 32'hFFFF_FFFF});

    // w_valid stalls of 3 cycles between beats
    bq = rq_d.size(); bd = done_cnt; bl = lwe_cnt;
    start_job(1);
    load_w(ID_W, 3);
    send_vec(32'h0403_0201, t0);
    wait_done(bd, 40);
    repeat (3) step();
    chk("t4_lwe", lwe_cnt - bl, 4);
    chk("t4_nres", rq_d.size() - bq, 1);
    chk("t4_lat", rq_c[bq] - t0, L);
    chk("t4_data", rq_d[bq], {32'd4, 32'd3, 32'd2, 32'd1});

    // num_vecs = 0
    bq = rq_d.size(); bd = done_cnt; ba = ar_cnt;
    start_job(0);
    load_w(ONES_W, 0);
    a_valid = 1'b1;
    a_data = 32'h1111_1111;
    wait_done(bd, 40);
    a_valid = 1'b0;
    a_data = '0;
    repeat (3) step();
    chk("t5_nres", rq_d.size() - bq, 0);
    chk("t5_a_ready", ar_cnt - ba, 0);
    chk("t5_ndone", done_cnt - bd, 1);
    chk("t5_busy_low", busy, 1'b0);

    // reset in the middle of streaming
    start_job(5);
    load_w(ID_W, 0);
    send_vec(32'h0101_0101, t0);
    send_vec(32'h0202_0202, t0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {busy, done, w_ready, a_ready, load_weight_en, r_valid}, 6'b0);
    chk("t6_rst_a_in", arr_a_in, '0);
    chk("t6_rst_sum_in", arr_sum_in, '0);
    chk("t6_rst_rdata", r_data, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bq = rq_d.size(); bd = done_cnt;
    repeat (20) step();
    chk("t6_no_res", rq_d.size() - bq, 0);
    chk("t6_no_done", done_cnt - bd, 0);
    start_job(1);
    load_w(ID_W, 0);
    send_vec(32'h0607_0809, t0);
    wait_done(bd, 40);
    repeat (3) step();
    chk("t6_nres", rq_d.size() - bq, 1);
    chk("t6_lat", rq_c[bq] - t0, L);
    chk("t6_data", rq_d[bq], {32'd6, 32'd7, 32'd8, 32'd9});
    chk("t6_ndone", done_cnt - bd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
